// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion (Nk = 4/6/8): one 32-bit schedule word per clock, stored for random-access round-key reads.
// Latency: 4*(Nr+1)-Nk cycles from accepted start to done; read port 1 cycle. start is ignored while busy.
module aes_key_schedule_seq #(
  parameter int regSize   = 32,
  parameter int vecSize   = 4,
  parameter int KEY_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [KEY_WORDS-1:0][regSize-1:0] key_in,
  output logic                              busy,
  output logic                              done,
  output logic                              ready,
  input  logic [3:0]                        rd_round,
  output logic [vecSize-1:0][regSize-1:0]   rd_key
);
  localparam int         NR      = KEY_WORDS + 6;
  localparam int         NW      = vecSize * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(KEY_WORDS);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [2:0] NK_LAST = 3'(KEY_WORDS - 1);
  localparam logic [3:0] NR_R    = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table is written with entry 0 in the top byte, so index from the bottom with ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_nxt;

  logic [5:0]               idx;
  logic [2:0]               mod_cnt;
  logic [3:0]               rcon_idx;
  logic                     accept, wr_exp, last_word;
  logic [regSize-1:0]       w [NW];
  logic [31:0]              prev_w, old_w, sub_in, sub_out, f_out, new_word;
  logic [5:0]               rd_base;
  logic [vecSize-1:0][regSize-1:0] rd_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wr_exp    = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        wr_exp = 1'b1;
        if (idx == LAST_W) begin
          last_word = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mod_cnt tracks i mod Nk; the extra SubWord for AES-256 lands halfway through each Nk group.
  always_comb begin
    prev_w  = w[idx - 6'd1];
    old_w   = w[idx - NK_W];
    sub_in  = (mod_cnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (mod_cnt == 3'd0)                           f_out = sub_out ^ {rcon_of(rcon_idx), 24'h0};
    else if (KEY_WORDS == 8 && mod_cnt == 3'd4)    f_out = sub_out;
    else                                           f_out = prev_w;
    new_word = old_w ^ f_out;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < KEY_WORDS; k++) w[k] <= key_in[k];
    end else if (wr_exp) begin
      w[idx] <= new_word;
    end
  end

  always_comb begin
    rd_base  = {rd_round, 2'b00};
    rd_words = '0;
    for (int j = 0; j < vecSize; j++) rd_words[j] = w[rd_base + 6'(j)];
  end

  assign busy = (state == EXPAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      mod_cnt  <= '0;
      rcon_idx <= '0;
      done     <= 1'b0;
      ready    <= 1'b0;
      rd_key   <= '0;
    end else begin
      done <= last_word;
      if (accept) begin
        idx      <= NK_W;
        mod_cnt  <= '0;
        rcon_idx <= 4'd1;
        ready    <= 1'b0;
      end else if (wr_exp) begin
        idx <= idx + 6'd1;
        if (mod_cnt == NK_LAST) begin
          mod_cnt  <= '0;
          rcon_idx <= rcon_idx + 4'd1;
        end else begin
          mod_cnt <= mod_cnt + 3'd1;
        end
      end
      if (last_word) ready <= 1'b1;
      rd_key <= (ready && rd_round <= NR_R) ? rd_words : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: AES-128 and AES-256 instances against known round keys.
module tb_aes_key_schedule_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start4, busy4, done4, ready4;
  logic [3:0][31:0]  key4;
  logic [3:0]        rd_round4;
  logic [3:0][31:0]  rd_key4;
  logic              start8, busy8, done8, ready8;
  logic [7:0][31:0]  key8;
  logic [3:0]        rd_round8;
  logic [3:0][31:0]  rd_key8;

  aes_key_schedule_seq #(.regSize(32), .vecSize(4), .KEY_WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4), .busy(busy4),
    .done(done4), .ready(ready4), .rd_round(rd_round4), .rd_key(rd_key4)
  );

  aes_key_schedule_seq #(.regSize(32), .vecSize(4), .KEY_WORDS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8), .busy(busy8),
    .done(done8), .ready(ready8), .rd_round(rd_round8), .rd_key(rd_key8)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [127:0] rk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key4(input logic [127:0] k);
    key4      = k;
    rd_round4 = 4'd0;
    start4    = 1'b1;
    tick();
    start4    = 1'b0;
  endtask

  // Counts edges after acceptance until done; optional stray start pulses at cycles p1/p2.
  task automatic wait4(input int p1, input int p2, output int n);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 3) check("gate_while_busy", rd_key4, 128'h0);
      start4 = (n == p1) || (n == p2);
    end while (!done4 && n < 200);
    start4 = 1'b0;
  endtask

  task automatic read4(input int r, output logic [127:0] v);
    rd_round4 = 4'(r);
    tick();
    v = rd_key4;
  endtask

  localparam logic [127:0] FIPS_KEY = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};

  initial begin
    int n;
    int done_seen;
    logic [127:0] v;

    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0; key4 = '0; key8 = '0;
    rd_round4 = 4'd0; rd_round8 = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_ready", ready4, 1'b0);
    check("rst_rd_key", rd_key4, 128'h0);

    // FIPS-197 key, with stray start pulses mid-expansion
    start_key4(FIPS_KEY);
    check("busy_after_accept", busy4, 1'b1);
    wait4(5, 20, n);
    check("fips_latency", n, 40);
    check("fips_ready", ready4, 1'b1);
    check("fips_busy_low", busy4, 1'b0);
    tick();
    check("done_one_cycle", done4, 1'b0);
    read4(0, v);  check("fips_r0", v, FIPS_KEY);
    read4(1, v);  check("fips_r1", v, rk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
    read4(10, v); check("fips_r10", v, rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
    read4(11, v); check("rd_round_oob", v, 128'h0);

    // All-zero key
    start_key4(128'h0);
    wait4(0, 0, n);
    check("zero_latency", n, 40);
    read4(1, v);  check("zero_r1", v, rk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363));
    read4(10, v); check("zero_r10", v, rk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e));

    // Back-to-back: restart in the cycle after done
    start_key4(FIPS_KEY);
    wait4(0, 0, n);
    start_key4(128'h0);
    check("b2b_ready_drop", ready4, 1'b0);
    wait4(0, 0, n);
    check("b2b_latency", n, 40);
    read4(10, v); check("b2b_r10", v, rk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e));

    // Reset in the middle of an expansion
    start_key4(FIPS_KEY);
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy4, 1'b0);
    check("midrst_done", done4, 1'b0);
    check("midrst_ready", ready4, 1'b0);
    check("midrst_rd_key", rd_key4, 128'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (done4) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_ready_low", ready4, 1'b0);
    start_key4(FIPS_KEY);
    wait4(0, 0, n);
    check("post_rst_latency", n, 40);
    read4(10, v); check("post_rst_r10", v, rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));

    // AES-256
    key8 = {32'h1c1d1e1f, 32'h18191a1b, 32'h14151617, 32'h10111213,
            32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 200);
    check("aes256_latency", n, 52);
    rd_round8 = 4'd1;  tick();
    check("aes256_r1", rd_key8, rk(32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f));
    rd_round8 = 4'd2;  tick();
    check("aes256_w8", rd_key8[0], 32'ha573c29f);
    rd_round8 = 4'd14; tick();
    check("aes256_r14", rd_key8, rk(32'h24fc79cc, 32'hbf0979e9, 32'h371ac23c, 32'h6d68de36));
    rd_round8 = 4'd15; tick();
    check("aes256_oob", rd_key8, 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Iterative, parametrised AES key-schedule engine for the SIMD crypto datapath. It expands a 128-, 192- or 256-bit cipher key into the full round-key array, producing one 32-bit schedule word per clock, and stores the result in an internal buffer. Once expansion finishes, the vector lanes read any 128-bit round key by index. It supersedes the single-round combinational AES-128 key expansion: it covers all three key sizes, adds a start/busy/done handshake, and keeps every round key for random-access reads.

## Interface
- regSize, 32, width of one schedule word; fixed at 32 (AES word)
- vecSize, 4, words per round key (Nb); fixed at 4
- KEY_WORDS, 4, key length in words (Nk); legal values 4, 6, 8; Nr = KEY_WORDS+6, total words NW = 4*(Nr+1) = 44/52/60

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request expansion; sampled only when idle
- key_in  in  [KEY_WORDS-1:0][regSize-1:0]  cipher key; word 0 = first key word; byte 0 = bits [31:24]
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the last word is written
- ready  out  1  buffer holds a complete, valid schedule
- rd_round  in  4  round-key index 0..Nr
- rd_key  out  [vecSize-1:0][regSize-1:0]  registered round key; rd_key[j] = w[4*rd_round+j]

## Operation
- States: IDLE and EXPAND.
- **IDLE, start=1 at an edge:**
  - write key_in[0..Nk-1] into w[0..Nk-1]
  - set i=Nk, busy=1, ready=0
  - go to EXPAND
  - key_in is sampled only at this edge.
- **EXPAND, each edge:** write w[i] = w[i-Nk] ^ f(w[i-1]), then i++.
  - f(t) when i mod Nk == 0: SubWord(RotWord(t)) ^ {Rcon[i/Nk],24'h0}. RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
  - f(t) when Nk==8 and i mod 4 == 0 (with i mod 8 != 0): SubWord(t).
  - f(t) otherwise: t.
  - SubWord applies the AES S-box to each byte, using 4 S-box instances.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Keep i/Nk and i mod Nk as running counters, not dividers.
- **When w[NW-1] is written:** busy=0, done=1 for exactly one cycle, ready=1, return to IDLE.
- **start while busy:** ignored; expansion continues undisturbed.
- **start while IDLE with ready=1:** restarts. ready drops at the accepting edge, and the old contents are invalid.
- **Read port:**
  - rd_key registers buffer words 4*rd_round..4*rd_round+3 every cycle.
  - It outputs all zeros when ready=0 or rd_round>Nr.
- **Buffer:** NW x 32 registers. Contents are not reset; reads are gated by ready.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, i=0, busy=0, done=0, ready=0, rd_key=0.
- Reset mid-expansion aborts immediately: ready stays 0 and no done pulse is produced.
- Start accepted at edge E0. Words Nk..NW-1 are written at edges E1..E(NW-Nk).
- done and ready rise after edge E(NW-Nk):
  - AES-128: 40 cycles after acceptance
  - AES-192: 46 cycles
  - AES-256: 52 cycles
- busy is high from after E0 until the edge where done rises.
- Back-to-back: start may be accepted at the edge following the done cycle.
- Read latency is 1 cycle: rd_round applied before edge N gives rd_key after edge N. The same-cycle ready gate uses the ready value before the edge.
- One S-box pass per cycle. No multi-cycle paths.

## Test plan
- **AES-128, all-zero key** -> done exactly 40 cycles after start.
  - round 1 = 62636363 62636363 62636363 62636363
  - round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e
- **AES-128, FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c:**
  - round 0 = the key
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605
  - round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6
- **AES-256 (KEY_WORDS=8), key 00010203..1c1d1e1f:**
  - done after 52 cycles
  - round 1 = 10111213 14151617 18191a1b 1c1d1e1f
  - w[8] = a573c29f
  - round 14 = 24fc79cc bf0979e9 371ac23c 6d68de36
- **Handshake:**
  - pulse start again at cycles 5 and 20 of an expansion -> ignored; done still at cycle 40; schedule unchanged.
  - start in the done cycle +1 with a new key -> ready drops, new schedule appears 40 cycles later.
- **Reset mid-op:** assert rst_n=0 at cycle 17 -> busy, done, ready and rd_key go to 0 asynchronously. A new start after release yields correct keys.
- **Read gating:**
  - rd_round=11 on AES-128 -> rd_key=0
  - any rd_round while ready=0 -> rd_key=0
  - rd_round=0 after done -> key_in echoed one cycle later
